// File: rtl/lsu_pkg.sv
// Shared opcodes, funct3 codes, FSM state encoding and access-size helper for the MEM-stage LSU.
package lsu_pkg;

    localparam logic [6:0] INST_TYPE_L = 7'b0000011;
    localparam logic [6:0] INST_TYPE_S = 7'b0100011;

    localparam logic [2:0] INST_LB  = 3'b000;
    localparam logic [2:0] INST_LH  = 3'b001;
    localparam logic [2:0] INST_LW  = 3'b010;
    localparam logic [2:0] INST_LD  = 3'b011;
    localparam logic [2:0] INST_LBU = 3'b100;
    localparam logic [2:0] INST_LHU = 3'b101;
    localparam logic [2:0] INST_LWU = 3'b110;

    localparam logic [2:0] INST_SB  = 3'b000;
    localparam logic [2:0] INST_SH  = 3'b001;
    localparam logic [2:0] INST_SW  = 3'b010;
    localparam logic [2:0] INST_SD  = 3'b011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_e;

    // log2 of the access size in bytes (0=byte .. 3=doubleword)
    function automatic logic [1:0] access_size(input logic [2:0] funct3);
        logic [1:0] sz;
        case (funct3[1:0])
            2'b00:   sz = 2'd0;
            2'b01:   sz = 2'd1;
            2'b10:   sz = 2'd2;
            default: sz = 2'd3;
        endcase
        return sz;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: store data replication, byte strobes, and load extract/extend.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 64,
    localparam int NB = XLEN / 8,
    localparam int OFF_W = $clog2(XLEN / 8)
) (
    input  logic [2:0]       funct3_i,
    input  logic [OFF_W-1:0] offset_i,
    input  logic [XLEN-1:0]  st_data_i,
    input  logic [XLEN-1:0]  rd_word_i,
    output logic [XLEN-1:0]  st_data_o,
    output logic [NB-1:0]    wstrb_o,
    output logic [XLEN-1:0]  ld_data_o
);

    logic [NB-1:0]   lane_mask_s;
    logic [XLEN-1:0] shifted_s;

    // Replicating the store operand at its own size lets any aligned offset pick the right lanes.
    always_comb begin
        case (access_size(funct3_i))
            2'd0: begin
                st_data_o   = {NB{st_data_i[7:0]}};
                lane_mask_s = NB'(8'h01);
            end
            2'd1: begin
                st_data_o   = {(NB/2){st_data_i[15:0]}};
                lane_mask_s = NB'(8'h03);
            end
            2'd2: begin
                st_data_o   = {(NB/4){st_data_i[31:0]}};
                lane_mask_s = NB'(8'h0F);
            end
            default: begin
                st_data_o   = st_data_i;
                lane_mask_s = '1;
            end
        endcase
        wstrb_o   = lane_mask_s << offset_i;
        shifted_s = rd_word_i >> {offset_i, 3'b000};
        case (funct3_i)
            INST_LB:  ld_data_o = XLEN'($signed(shifted_s[7:0]));
            INST_LH:  ld_data_o = XLEN'($signed(shifted_s[15:0]));
            INST_LW:  ld_data_o = XLEN'($signed(shifted_s[31:0]));
            INST_LBU: ld_data_o = XLEN'(shifted_s[7:0]);
            INST_LHU: ld_data_o = XLEN'(shifted_s[15:0]);
            INST_LWU: ld_data_o = XLEN'(shifted_s[31:0]);
            INST_LD:  ld_data_o = shifted_s;
            default:  ld_data_o = '0;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: one valid/ready D-cache request per access, stalls ctrl until done.
// Optional feature macro LSU_MISALIGN_TRAP_EN: misaligned accesses trap instead of being force-aligned.
module mem_lsu
    import lsu_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int IDX_W  = 12,
    parameter int ADDR_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          inst_i,
    input  logic [ADDR_W-1:0]    mem_addr_i,
    input  logic [XLEN-1:0]      op2_i,
    input  logic [4:0]           rd_addr_i,
    input  logic [XLEN-1:0]      rd_data_i,
    input  logic                 rd_wen_i,
    input  logic                 int_assert_i,
    output logic [4:0]           rd_addr_o,
    output logic [XLEN-1:0]      rd_data_o,
    output logic                 rd_wen_o,
    output logic                 hold_flag_mem_o,
    output logic                 dcache_req_valid,
    input  logic                 dcache_req_ready,
    output logic                 dcache_req_rw,
    output logic [IDX_W-1:0]     dcache_req_addr,
    output logic [XLEN/8-1:0]    dcache_req_wstrb,
    output logic [XLEN-1:0]      dcache_data_write,
    input  logic                 dcache_rsp_valid,
    input  logic [XLEN-1:0]      dcache_data_read,
    output logic                 misalign_o
);

    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);

    lsu_state_e       state_q;
    logic             req_valid_q;
    logic             req_rw_q;
    logic [IDX_W-1:0] req_addr_q;
    logic [NB-1:0]    req_wstrb_q;
    logic [XLEN-1:0]  req_wdata_q;
    logic [2:0]       funct3_q;
    logic [OFF_W-1:0] off_q;
    logic [4:0]       rd_addr_q;
    logic [XLEN-1:0]  ld_data_q;

    logic [6:0]       opcode_s;
    logic [2:0]       funct3_s;
    logic             is_load_s;
    logic             is_store_s;
    logic             legal_s;
    logic [2:0]       size_mask_s;
    logic [OFF_W-1:0] raw_off_s;
    logic [OFF_W-1:0] off_s;
    logic             misaligned_s;
    logic             launch_s;
    logic             trap_s;
    logic [2:0]       align_f3_s;
    logic [OFF_W-1:0] align_off_s;
    logic [XLEN-1:0]  align_wdata_s;
    logic [NB-1:0]    align_wstrb_s;
    logic [XLEN-1:0]  align_ld_s;
    logic             unused_s;

    assign unused_s = ^{mem_addr_i[ADDR_W-1:IDX_W+OFF_W], inst_i[31:15]};

    // Decode the instruction in MEM and decide whether an access launches this cycle.
    always_comb begin
        opcode_s   = inst_i[6:0];
        funct3_s   = inst_i[14:12];
        is_load_s  = (opcode_s == INST_TYPE_L);
        is_store_s = (opcode_s == INST_TYPE_S);
        legal_s    = 1'b0;
        if (is_load_s) begin
            case (funct3_s)
                INST_LB, INST_LH, INST_LW, INST_LBU, INST_LHU: legal_s = 1'b1;
                INST_LD, INST_LWU:                             legal_s = (XLEN == 64);
                default:                                       legal_s = 1'b0;
            endcase
        end else if (is_store_s) begin
            case (funct3_s)
                INST_SB, INST_SH, INST_SW: legal_s = 1'b1;
                INST_SD:                   legal_s = (XLEN == 64);
                default:                   legal_s = 1'b0;
            endcase
        end else begin
            legal_s = 1'b0;
        end
        case (access_size(funct3_s))
            2'd0:    size_mask_s = 3'd0;
            2'd1:    size_mask_s = 3'd1;
            2'd2:    size_mask_s = 3'd3;
            default: size_mask_s = 3'd7;
        endcase
        raw_off_s    = mem_addr_i[OFF_W-1:0];
        misaligned_s = |(raw_off_s & size_mask_s[OFF_W-1:0]);
`ifdef LSU_MISALIGN_TRAP_EN
        off_s    = raw_off_s;
        launch_s = legal_s && !int_assert_i && !misaligned_s;
        trap_s   = legal_s && !int_assert_i && misaligned_s;
`else
        off_s    = raw_off_s & ~size_mask_s[OFF_W-1:0];
        launch_s = legal_s && !int_assert_i;
        trap_s   = 1'b0;
`endif
    end

    assign align_f3_s  = (state_q == ST_IDLE) ? funct3_s : funct3_q;
    assign align_off_s = (state_q == ST_IDLE) ? off_s : off_q;

    lsu_align #(.XLEN(XLEN)) u_align (
        .funct3_i  (align_f3_s),
        .offset_i  (align_off_s),
        .st_data_i (op2_i),
        .rd_word_i (dcache_data_read),
        .st_data_o (align_wdata_s),
        .wstrb_o   (align_wstrb_s),
        .ld_data_o (align_ld_s)
    );

    // Access FSM with capture registers; request fields are frozen from launch until accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            req_valid_q <= 1'b0;
            req_rw_q    <= 1'b0;
            req_addr_q  <= '0;
            req_wstrb_q <= '0;
            req_wdata_q <= '0;
            funct3_q    <= 3'd0;
            off_q       <= '0;
            rd_addr_q   <= 5'd0;
            ld_data_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (launch_s) begin
                        state_q     <= ST_REQ;
                        req_valid_q <= 1'b1;
                        req_rw_q    <= is_store_s;
                        req_addr_q  <= mem_addr_i[IDX_W+OFF_W-1:OFF_W];
                        req_wstrb_q <= is_store_s ? align_wstrb_s : '0;
                        req_wdata_q <= is_store_s ? align_wdata_s : '0;
                        funct3_q    <= funct3_s;
                        off_q       <= off_s;
                        rd_addr_q   <= is_load_s ? inst_i[11:7] : 5'd0;
                    end
                end
                ST_REQ: begin
                    if (dcache_req_ready) begin
                        state_q     <= ST_RESP;
                        req_valid_q <= 1'b0;
                    end
                end
                ST_RESP: begin
                    if (dcache_rsp_valid) begin
                        state_q <= ST_DONE;
                        if (!req_rw_q) begin
                            ld_data_q <= align_ld_s;
                        end
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: begin
                    state_q     <= ST_IDLE;
                    req_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign dcache_req_valid  = req_valid_q;
    assign dcache_req_rw     = req_rw_q;
    assign dcache_req_addr   = req_addr_q;
    assign dcache_req_wstrb  = req_wstrb_q;
    assign dcache_data_write = req_wdata_q;

    // Writeback/stall outputs; reset forces them low even while pass-through inputs are active.
    always_comb begin
        rd_addr_o       = 5'd0;
        rd_data_o       = '0;
        rd_wen_o        = 1'b0;
        hold_flag_mem_o = 1'b0;
        misalign_o      = 1'b0;
        if (rst) begin
            rd_wen_o = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (is_load_s || is_store_s) begin
                        hold_flag_mem_o = launch_s;
                        misalign_o      = trap_s;
                    end else begin
                        rd_addr_o = rd_addr_i;
                        rd_data_o = rd_data_i;
                        rd_wen_o  = rd_wen_i;
                    end
                end
                ST_REQ, ST_RESP: hold_flag_mem_o = 1'b1;
                ST_DONE: begin
                    if (!req_rw_q) begin
                        rd_addr_o = rd_addr_q;
                        rd_data_o = ld_data_q;
                        rd_wen_o  = 1'b1;
                    end else begin
                        rd_wen_o = 1'b0;
                    end
                end
                default: hold_flag_mem_o = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu (XLEN=64): directed scenarios plus randomized accesses vs a byte-level model.
module tb_mem_lsu;

    localparam logic [6:0] OP_L   = 7'b0000011;
    localparam logic [6:0] OP_S   = 7'b0100011;
    localparam logic [6:0] OP_ADD = 7'b0110011;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] inst_i;
    logic [31:0] mem_addr_i;
    logic [63:0] op2_i;
    logic [4:0]  rd_addr_i;
    logic [63:0] rd_data_i;
    logic        rd_wen_i;
    logic        int_assert_i;
    logic [4:0]  rd_addr_o;
    logic [63:0] rd_data_o;
    logic        rd_wen_o;
    logic        hold_flag_mem_o;
    logic        dcache_req_valid;
    logic        dcache_req_ready;
    logic        dcache_req_rw;
    logic [11:0] dcache_req_addr;
    logic [7:0]  dcache_req_wstrb;
    logic [63:0] dcache_data_write;
    logic        dcache_rsp_valid;
    logic [63:0] dcache_data_read;
    logic        misalign_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_lsu dut (
        .clk(clk), .rst(rst), .inst_i(inst_i), .mem_addr_i(mem_addr_i), .op2_i(op2_i),
        .rd_addr_i(rd_addr_i), .rd_data_i(rd_data_i), .rd_wen_i(rd_wen_i),
        .int_assert_i(int_assert_i), .rd_addr_o(rd_addr_o), .rd_data_o(rd_data_o),
        .rd_wen_o(rd_wen_o), .hold_flag_mem_o(hold_flag_mem_o),
        .dcache_req_valid(dcache_req_valid), .dcache_req_ready(dcache_req_ready),
        .dcache_req_rw(dcache_req_rw), .dcache_req_addr(dcache_req_addr),
        .dcache_req_wstrb(dcache_req_wstrb), .dcache_data_write(dcache_data_write),
        .dcache_rsp_valid(dcache_rsp_valid), .dcache_data_read(dcache_data_read),
        .misalign_o(misalign_o)
    );

    // Reference: pick n bytes starting at byte 'off' of the word, then extend by funct3 rule.
    function automatic logic [63:0] exp_load(input logic [2:0] f3, input int off, input logic [63:0] w);
        int n;
        logic [63:0] v;
        logic [63:0] m;
        n = 1 << f3[1:0];
        v = w >> (8 * off);
        if (n < 8) begin
            m = (64'd1 << (8 * n)) - 64'd1;
            v = v & m;
            if (!f3[2] && v[8*n-1]) v = v | ~m;
        end
        return v;
    endfunction

    task automatic drive_nop(input logic [4:0] a, input logic [63:0] d);
        logic [31:0] r;
        r = $urandom();
        inst_i = {r[31:7], OP_ADD};
        mem_addr_i = $urandom();
        rd_addr_i = a;
        rd_data_i = d;
        rd_wen_i = 1'b1;
        int_assert_i = 1'b0;
        dcache_req_ready = 1'b0;
        dcache_rsp_valid = 1'b0;
    endtask

    // One complete access with a cache model of configurable ready/response delays.
    task automatic run_access(input logic [2:0] f3, input logic st, input logic [31:0] addr,
                              input logic [63:0] op2, input logic [63:0] rword,
                              input int rdy_wait, input int rsp_wait, input logic int_req);
        logic [31:0] r;
        logic [4:0]  rd;
        logic [7:0]  exp_strb;
        logic [63:0] exp_data;
        logic [11:0] exp_idx;
        int n;
        int off;
        logic mis;
        r = $urandom();
        rd = 5'($urandom_range(1, 31));
        n = 1 << f3[1:0];
        mis = (addr[2:0] % n) != 0;
        off = int'(addr[2:0]) - int'(addr[2:0]) % n;
        exp_strb = st ? 8'(((1 << n) - 1) << off) : 8'h00;
        exp_data = st ? 64'd0 : exp_load(f3, off, rword);
        exp_idx = addr[14:3];
        @(posedge clk); #1;
        inst_i = {r[31:15], f3, rd, st ? OP_S : OP_L};
        mem_addr_i = addr; op2_i = op2; rd_addr_i = rd; rd_data_i = {r, r}; rd_wen_i = 1'b1;
        int_assert_i = 1'b0; dcache_req_ready = 1'b0; dcache_rsp_valid = 1'b0;
        #2;
`ifdef LSU_MISALIGN_TRAP_EN
        if (mis) begin
            total++;
            if ({hold_flag_mem_o, dcache_req_valid, rd_wen_o, misalign_o} !== 4'b0001) begin
                bad++; $display("FAIL trap_idle got=%b exp=0001", {hold_flag_mem_o, dcache_req_valid, rd_wen_o, misalign_o});
            end
            @(posedge clk); #1; drive_nop(5'd3, 64'h77); #2;
            total++;
            if ({dcache_req_valid, misalign_o, rd_data_o} !== {2'b00, 64'h77}) begin
                bad++; $display("FAIL trap_after got=%b/%b/%h exp=0/0/77", dcache_req_valid, misalign_o, rd_data_o);
            end
            return;
        end
`endif
        total++;
        if ({hold_flag_mem_o, dcache_req_valid, rd_wen_o, misalign_o} !== 4'b1000) begin
            bad++; $display("FAIL launch got=%b exp=1000", {hold_flag_mem_o, dcache_req_valid, rd_wen_o, misalign_o});
        end
        for (int k = 0; k <= rdy_wait; k++) begin
            @(posedge clk); #1;
            dcache_req_ready = (k == rdy_wait);
            int_assert_i = int_req;
            #2;
            total++;
            if ({hold_flag_mem_o, dcache_req_valid, rd_wen_o, dcache_req_rw, dcache_req_addr, dcache_req_wstrb}
                !== {3'b110, st, exp_idx, exp_strb}) begin
                bad++;
                $display("FAIL req k=%0d got hold/valid/wen=%b rw=%b idx=%h strb=%h exp 110 %b %h %h", k,
                         {hold_flag_mem_o, dcache_req_valid, rd_wen_o}, dcache_req_rw, dcache_req_addr,
                         dcache_req_wstrb, st, exp_idx, exp_strb);
            end
            for (int i = 0; i < 8; i++) begin
                if (exp_strb[i]) begin
                    total++;
                    if (dcache_data_write[8*i +: 8] !== op2[8*(i-off) +: 8]) begin
                        bad++; $display("FAIL wlane%0d got=%h exp=%h", i, dcache_data_write[8*i +: 8], op2[8*(i-off) +: 8]);
                    end
                end
            end
        end
        @(posedge clk); #1;
        dcache_req_ready = 1'b0;
        int_assert_i = 1'b0;
        for (int k = 0; k <= rsp_wait; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            dcache_rsp_valid = (k == rsp_wait);
            dcache_data_read = (k == rsp_wait) ? rword : {$urandom(), $urandom()};
            #2;
            total++;
            if ({hold_flag_mem_o, dcache_req_valid, rd_wen_o} !== 3'b100) begin
                bad++; $display("FAIL resp k=%0d got=%b exp=100", k, {hold_flag_mem_o, dcache_req_valid, rd_wen_o});
            end
        end
        @(posedge clk); #1;
        dcache_rsp_valid = 1'b0;
        dcache_data_read = {$urandom(), $urandom()};
        #2;
        total++;
        if ({hold_flag_mem_o, dcache_req_valid, rd_wen_o, rd_addr_o, rd_data_o}
            !== {2'b00, !st, st ? 5'd0 : rd, exp_data}) begin
            bad++;
            $display("FAIL done got hold/valid/wen=%b rd=%0d data=%h exp 00%b rd=%0d data=%h",
                     {hold_flag_mem_o, dcache_req_valid, rd_wen_o}, rd_addr_o, rd_data_o,
                     !st, st ? 5'd0 : rd, exp_data);
        end
        @(posedge clk); #1;
        drive_nop(5'd9, 64'h1234);
        #2;
        total++;
        if ({hold_flag_mem_o, rd_wen_o, rd_data_o} !== {2'b01, 64'h1234}) begin
            bad++; $display("FAIL post_idle got=%b/%h exp=01/1234", {hold_flag_mem_o, rd_wen_o}, rd_data_o);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        op2_i = '0;
        dcache_data_read = '0;
        drive_nop(5'd4, 64'hDEAD);
        #3;
        total++;
        if ({dcache_req_valid, hold_flag_mem_o, rd_wen_o, misalign_o, rd_addr_o, rd_data_o,
             dcache_req_rw, dcache_req_addr, dcache_req_wstrb, dcache_data_write} !== '0) begin
            bad++; $display("FAIL reset_outputs not zero: wen=%b rd=%0d data=%h valid=%b", rd_wen_o, rd_addr_o, rd_data_o, dcache_req_valid);
        end
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        #2;
        total++;
        if ({rd_wen_o, rd_addr_o, rd_data_o, hold_flag_mem_o} !== {1'b1, 5'd4, 64'hDEAD, 1'b0}) begin
            bad++; $display("FAIL reset_release got wen=%b rd=%0d data=%h", rd_wen_o, rd_addr_o, rd_data_o);
        end
    endtask

    task automatic test_passthrough();
        logic [31:0] r;
        logic [6:0] ops [4];
        ops[0] = OP_ADD; ops[1] = 7'b0010011; ops[2] = 7'b0110111; ops[3] = 7'b1101111;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            r = $urandom();
            inst_i = {r[31:7], ops[i % 4]};
            rd_addr_i = r[4:0]; rd_data_i = {$urandom(), $urandom()}; rd_wen_i = r[9];
            #2;
            total++;
            if ({rd_addr_o, rd_data_o, rd_wen_o, hold_flag_mem_o, dcache_req_valid}
                !== {rd_addr_i, rd_data_i, rd_wen_i, 2'b00}) begin
                bad++; $display("FAIL passthrough i=%0d got %0d/%h/%b exp %0d/%h/%b", i, rd_addr_o, rd_data_o, rd_wen_o,
                                rd_addr_i, rd_data_i, rd_wen_i);
            end
        end
    endtask

    task automatic test_directed();
        run_access(3'b010, 1'b0, 32'h104, 64'd0, 64'h80000001_00000000, 0, 0, 1'b0);
        run_access(3'b000, 1'b1, 32'h003, 64'hAB, 64'd0, 3, 1, 1'b0);
        run_access(3'b100, 1'b0, 32'h007, 64'd0, 64'hF0AA_5511_2233_4455, 1, 0, 1'b0);
        run_access(3'b000, 1'b0, 32'h007, 64'd0, 64'hF0AA_5511_2233_4455, 0, 2, 1'b0);
    endtask

    task automatic test_interrupt();
        @(posedge clk); #1;
        inst_i = {17'd0, 3'b011, 5'd6, OP_L};
        mem_addr_i = 32'h200; int_assert_i = 1'b1;
        #2;
        total++;
        if ({hold_flag_mem_o, dcache_req_valid, rd_wen_o} !== 3'b000) begin
            bad++; $display("FAIL int_idle got=%b exp=000", {hold_flag_mem_o, dcache_req_valid, rd_wen_o});
        end
        @(posedge clk); #1;
        int_assert_i = 1'b0;
        inst_i = {17'd0, 3'b000, 5'd6, OP_ADD};
        #2;
        total++;
        if (dcache_req_valid !== 1'b0) begin
            bad++; $display("FAIL int_no_req got=%b exp=0", dcache_req_valid);
        end
        run_access(3'b011, 1'b0, 32'h208, 64'd0, 64'h0123_4567_89AB_CDEF, 2, 1, 1'b1);
    endtask

    task automatic test_illegal();
        logic [2:0] f3s [3];
        logic       sts [3];
        f3s[0] = 3'b111; sts[0] = 1'b0;
        f3s[1] = 3'b101; sts[1] = 1'b1;
        f3s[2] = 3'b110; sts[2] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            inst_i = {17'd0, f3s[i], 5'd8, sts[i] ? OP_S : OP_L};
            mem_addr_i = 32'h40; rd_wen_i = 1'b1;
            #2;
            total++;
            if ({hold_flag_mem_o, dcache_req_valid, rd_wen_o} !== 3'b000) begin
                bad++; $display("FAIL illegal_idle i=%0d got=%b exp=000", i, {hold_flag_mem_o, dcache_req_valid, rd_wen_o});
            end
            @(posedge clk); #1; drive_nop(5'd1, 64'd1); #2;
            total++;
            if (dcache_req_valid !== 1'b0) begin
                bad++; $display("FAIL illegal_no_req i=%0d got=%b exp=0", i, dcache_req_valid);
            end
        end
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        inst_i = {17'd0, 3'b010, 5'd5, OP_L};
        mem_addr_i = 32'h10;
        @(posedge clk); #1;
        dcache_req_ready = 1'b1;
        @(posedge clk); #1;
        dcache_req_ready = 1'b0;
        #1;
        total++;
        if (hold_flag_mem_o !== 1'b1) begin
            bad++; $display("FAIL mid_in_resp hold got=%b exp=1", hold_flag_mem_o);
        end
        rst = 1'b1;
        #1;
        total++;
        if ({dcache_req_valid, hold_flag_mem_o, rd_wen_o, rd_addr_o, rd_data_o} !== '0) begin
            bad++; $display("FAIL mid_reset got valid=%b hold=%b wen=%b", dcache_req_valid, hold_flag_mem_o, rd_wen_o);
        end
        drive_nop(5'd2, 64'h55);
        #1;
        total++;
        if ({rd_wen_o, rd_data_o} !== '0) begin
            bad++; $display("FAIL mid_reset_gate got wen=%b data=%h exp 0/0", rd_wen_o, rd_data_o);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        total++;
        if ({rd_wen_o, rd_addr_o, rd_data_o, hold_flag_mem_o, dcache_req_valid} !== {1'b1, 5'd2, 64'h55, 2'b00}) begin
            bad++; $display("FAIL mid_release got wen=%b rd=%0d data=%h exp 1/2/55", rd_wen_o, rd_addr_o, rd_data_o);
        end
    endtask

    task automatic test_misalign();
        run_access(3'b001, 1'b0, 32'h001, 64'd0, 64'h1122_3344_5566_8899, 0, 0, 1'b0);
        run_access(3'b010, 1'b1, 32'h306, 64'hCAFE_BABE, 64'd0, 1, 0, 1'b0);
        run_access(3'b011, 1'b1, 32'h404, 64'h0102_0304_0506_0708, 64'd0, 0, 1, 1'b0);
    endtask

    task automatic test_random();
        logic [31:0] r;
        logic [2:0]  f3;
        logic        st;
        for (int i = 0; i < 40; i++) begin
            r = $urandom();
            st = r[0];
            f3 = st ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 6));
            run_access(f3, st, $urandom(), {$urandom(), $urandom()}, {$urandom(), $urandom()},
                       $urandom_range(0, 3), $urandom_range(0, 3), r[1]);
        end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_directed();
        test_interrupt();
        test_illegal();
        test_misalign();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
